mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory controller (byte-serial RAM/IO port) among three requesters:
  - instruction cache fetch (IC)
  - load/store buffer (LSB)
  - instruction prefetcher (PF)
- Sits between the requesters and the controller's fetch and LSB ports.
- Owns grant selection, request holding, flush handling and anti-starvation.

Parameters:
- STARVE_LIMIT, 4: consecutive LSB grants allowed while IC waits before IC is forced.
- STARVE_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset; rst==0 at a clk edge resets
- rdy  in  1  global enable; 0 freezes all state and outputs
- clear  in  1  pipeline flush
- ic_req  in  1  IC fetch request, held until ic_done
- ic_addr  in  32  fetch address
- ic_gnt  out  1  one-cycle grant pulse
- ic_done  out  1  one-cycle completion pulse; data comes directly from controller
- lsb_req  in  1  LSB request, held until lsb_done
- lsb_addr  in  32  base address
- lsb_op  in  6  opcode (def.v encoding); op[5:3]==3'b111 is a store
- lsb_imm  in  32  offset
- lsb_val  in  32  store data / load RoB tag
- lsb_gnt  out  1  grant pulse
- lsb_done  out  1  completion pulse
- pf_req  in  1  prefetch request
- pf_addr  in  32  prefetch address
- pf_gnt  out  1  grant pulse
- pf_done  out  1  completion pulse
- mc_ic_ready  out  1  fetch request to controller, held for whole transaction
- mc_ic_addr  out  32  latched fetch address (IC or PF)
- mc_ic_ok  in  1  controller fetch-complete pulse
- mc_lsb_ready  out  1  LSB request to controller, held for whole transaction
- mc_lsb_addr, mc_lsb_imm, mc_lsb_val  out  32 each  latched LSB fields
- mc_lsb_op  out  6  latched opcode
- mc_lsb_done  in  1  controller LSB-complete pulse

Behaviour:
- Reset:
  - every output is 0
  - state is IDLE
  - starve_cnt is 0
  - the is_store flag is 0
- When rdy==0, nothing changes, including pulses.
- States: IDLE, BUSY_IC, BUSY_PF, BUSY_LSB, RELEASE.
- IDLE, with clear==0: pick a winner in this priority order.
  - LSB, if lsb_req && !(ic_req && starve_cnt==STARVE_LIMIT).
  - Otherwise IC, if ic_req.
  - Otherwise PF, if pf_req.
- On a grant, all of the following are registered at the same edge:
  - latch the winner's fields into the mc_* outputs
  - set the matching mc_*_ready
  - pulse x_gnt for 1 cycle
  - enter BUSY_x
  - grant is visible the cycle after the request is sampled
- IDLE with clear==1: no grant.
- Starvation counter:
  - LSB grant while ic_req==1: starve_cnt++, saturating at STARVE_LIMIT.
  - IC grant: starve_cnt cleared.
  - LSB grant while ic_req==0: starve_cnt cleared.
- BUSY_IC / BUSY_PF:
  - On mc_ic_ok: pulse ic_done or pf_done, deassert mc_ic_ready, go to RELEASE.
  - clear==1 before completion: deassert mc_ic_ready, go to RELEASE, no done pulse.
- BUSY_LSB:
  - On mc_lsb_done: pulse lsb_done, deassert mc_lsb_ready, go to RELEASE.
  - clear==1 during a load: abort as in BUSY_IC (no done pulse).
  - clear==1 during a store (is_store latched at grant) is ignored; committed stores always complete.
- RELEASE:
  - Exactly 1 cycle, then IDLE.
  - Gives the controller its return-to-idle cycle.
  - No grant is issued in RELEASE, so back-to-back grants are separated by at least 1 idle cycle.
- mc_*_addr/op/imm/val:
  - Hold their values after release.
  - Change only on a new grant.
- The two mc_*_ready outputs are never high together.
- Requesters must hold req until done. Requests are only sampled in IDLE; dropping a request in IDLE simply removes the candidate.
- Done and ok inputs arriving in a non-matching state are ignored.
- Reset mid-transaction: both mc readies drop at the reset edge.

Optional Feature:
- MEM_ARB_PREFETCH_EN.
- Defined: PF port participates at lowest priority as specified above.
- Undefined:
  - pf_req and pf_addr are ignored
  - pf_gnt and pf_done are tied 0
  - BUSY_PF is unreachable and removed
  - mc_ic_addr comes only from ic_addr

Decomposition:
- def.v holds:
  - state encodings ARB_IDLE, ARB_IC, ARB_PF, ARB_LSB, ARB_REL
  - the existing load/store opcodes LB..SW
  - an IS_STORE(op) macro
- One sub-module, mem_arb_pick: combinational priority/starvation selector. Inputs: reqs, starve_cnt, clear. Output: one-hot winner.

Test Plan:
- Reset: hold rst=0 for 2 cycles with all requests high -> every output is 0; first grant comes no earlier than the cycle after rst=1.
- ic_req (0x1000) and lsb_req (LW, addr 0x20, imm 4) raised together:
  - lsb_gnt the next cycle; mc_lsb_addr=0x20, mc_lsb_imm=4
  - after mc_lsb_done: lsb_done, 1 RELEASE cycle, then ic_gnt with mc_ic_addr=0x1000
- STARVE_LIMIT=2, lsb_req and ic_req held continuously -> grant order LSB, LSB, IC, LSB, LSB, IC.
- clear pulsed 3 cycles into a LW -> mc_lsb_ready low the next cycle, no lsb_done, IDLE after RELEASE.
- Same clear during SW addr 0x30000 -> store runs to mc_lsb_done and lsb_done fires.
- rdy=0 for 4 cycles mid BUSY_IC while mc_ic_ok pulses -> no state or output change; completes after rdy=1 and the ok pulse repeats.
- pf_req alone -> pf_gnt.
- pf_req and ic_req raised together -> IC wins.
- Build without MEM_ARB_PREFETCH_EN -> pf_gnt is never asserted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-controller arbiter: state encodings, LSB opcodes,
// latched command and registered-output bundles.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_IC   = 3'd1,
    ARB_PF   = 3'd2,
    ARB_LSB  = 3'd3,
    ARB_REL  = 3'd4
  } arb_state_e;

  // Loads live in 3'b110xxx, stores in 3'b111xxx.
  localparam logic [5:0] OP_LB  = 6'b110_000;
  localparam logic [5:0] OP_LH  = 6'b110_001;
  localparam logic [5:0] OP_LW  = 6'b110_010;
  localparam logic [5:0] OP_LBU = 6'b110_011;
  localparam logic [5:0] OP_LHU = 6'b110_100;
  localparam logic [5:0] OP_SB  = 6'b111_000;
  localparam logic [5:0] OP_SH  = 6'b111_001;
  localparam logic [5:0] OP_SW  = 6'b111_010;

  localparam int REQ_IC  = 0;
  localparam int REQ_LSB = 1;
  localparam int REQ_PF  = 2;

  typedef logic [2:0] req_vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] val;
  } lsb_cmd_t;

  typedef struct packed {
    logic        ic_gnt;
    logic        ic_done;
    logic        lsb_gnt;
    logic        lsb_done;
    logic        pf_gnt;
    logic        pf_done;
    logic        mc_ic_ready;
    logic        mc_lsb_ready;
    logic [31:0] mc_ic_addr;
    lsb_cmd_t    mc_lsb;
  } arb_out_t;

  function automatic logic is_store_op(input logic [5:0] op);
    return op[5:3] == 3'b111;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and controller signals of the memory arbiter; slave is the arbiter's
// view, master is the surrounding requesters plus controller.
interface mem_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt;
  logic        ic_done;

  logic        lsb_req;
  logic [31:0] lsb_addr;
  logic [5:0]  lsb_op;
  logic [31:0] lsb_imm;
  logic [31:0] lsb_val;
  logic        lsb_gnt;
  logic        lsb_done;

  logic        pf_req;
  logic [31:0] pf_addr;
  logic        pf_gnt;
  logic        pf_done;

  logic        mc_ic_ready;
  logic [31:0] mc_ic_addr;
  logic        mc_ic_ok;
  logic        mc_lsb_ready;
  logic [31:0] mc_lsb_addr;
  logic [5:0]  mc_lsb_op;
  logic [31:0] mc_lsb_imm;
  logic [31:0] mc_lsb_val;
  logic        mc_lsb_done;

  modport slave (
    input  ic_req, ic_addr, lsb_req, lsb_addr, lsb_op, lsb_imm, lsb_val,
           pf_req, pf_addr, mc_ic_ok, mc_lsb_done,
    output ic_gnt, ic_done, lsb_gnt, lsb_done, pf_gnt, pf_done,
           mc_ic_ready, mc_ic_addr, mc_lsb_ready, mc_lsb_addr, mc_lsb_op,
           mc_lsb_imm, mc_lsb_val
  );

  modport master (
    output ic_req, ic_addr, lsb_req, lsb_addr, lsb_op, lsb_imm, lsb_val,
           pf_req, pf_addr, mc_ic_ok, mc_lsb_done,
    input  ic_gnt, ic_done, lsb_gnt, lsb_done, pf_gnt, pf_done,
           mc_ic_ready, mc_ic_addr, mc_lsb_ready, mc_lsb_addr, mc_lsb_op,
           mc_lsb_imm, mc_lsb_val
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select: LSB > IC > PF, except IC is forced once LSB has
// won STARVE_LIMIT times in a row while IC was waiting.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 3
) (
  input  req_vec_t            reqs,
  input  logic [STARVE_W-1:0] starve_cnt,
  input  logic                clear,
  output req_vec_t            winner
);
  logic ic_starved;

  assign ic_starved = reqs[REQ_IC] && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  always_comb begin
    winner = '0;
    if (!clear) begin
      if (reqs[REQ_LSB] && !ic_starved) winner[REQ_LSB] = 1'b1;
      else if (reqs[REQ_IC])            winner[REQ_IC]  = 1'b1;
      else if (reqs[REQ_PF])            winner[REQ_PF]  = 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller among IC fetch, LSB and prefetcher.
// Optional prefetch port enabled with `define MEM_ARB_PREFETCH_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  input logic          clear,
  mem_arbiter_if.slave bus
);
  arb_state_e          state, state_n;
  logic [STARVE_W-1:0] starve_cnt, starve_n;
  logic                is_store, is_store_n;
  arb_out_t            out_q, out_n;
  req_vec_t            reqs, winner;
  lsb_cmd_t            lsb_cmd;

  assign lsb_cmd = '{addr: bus.lsb_addr, op: bus.lsb_op, imm: bus.lsb_imm, val: bus.lsb_val};

  assign reqs[REQ_IC]  = bus.ic_req;
  assign reqs[REQ_LSB] = bus.lsb_req;
`ifdef MEM_ARB_PREFETCH_EN
  assign reqs[REQ_PF]  = bus.pf_req;
`else
  assign reqs[REQ_PF]  = 1'b0;
`endif

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .STARVE_W    (STARVE_W)
  ) u_pick (
    .reqs      (reqs),
    .starve_cnt(starve_cnt),
    .clear     (clear),
    .winner    (winner)
  );

  always_comb begin
    state_n      = state;
    starve_n     = starve_cnt;
    is_store_n   = is_store;
    out_n        = out_q;
    out_n.ic_gnt   = 1'b0;
    out_n.ic_done  = 1'b0;
    out_n.lsb_gnt  = 1'b0;
    out_n.lsb_done = 1'b0;
    out_n.pf_gnt   = 1'b0;
    out_n.pf_done  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (winner[REQ_LSB]) begin
          out_n.lsb_gnt      = 1'b1;
          out_n.mc_lsb_ready = 1'b1;
          out_n.mc_lsb       = lsb_cmd;
          is_store_n         = is_store_op(bus.lsb_op);
          state_n            = ARB_LSB;
          // Only LSB wins taken while IC is waiting count toward starvation.
          if (!bus.ic_req)                                starve_n = '0;
          else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) starve_n = starve_cnt + STARVE_W'(1);
        end else if (winner[REQ_IC]) begin
          out_n.ic_gnt      = 1'b1;
          out_n.mc_ic_ready = 1'b1;
          out_n.mc_ic_addr  = bus.ic_addr;
          starve_n          = '0;
          state_n           = ARB_IC;
        end
`ifdef MEM_ARB_PREFETCH_EN
        else if (winner[REQ_PF]) begin
          out_n.pf_gnt      = 1'b1;
          out_n.mc_ic_ready = 1'b1;
          out_n.mc_ic_addr  = bus.pf_addr;
          state_n           = ARB_PF;
        end
`endif
      end
      ARB_IC: begin
        if (bus.mc_ic_ok) begin
          out_n.ic_done     = 1'b1;
          out_n.mc_ic_ready = 1'b0;
          state_n           = ARB_REL;
        end else if (clear) begin
          out_n.mc_ic_ready = 1'b0;
          state_n           = ARB_REL;
        end
      end
`ifdef MEM_ARB_PREFETCH_EN
      ARB_PF: begin
        if (bus.mc_ic_ok) begin
          out_n.pf_done     = 1'b1;
          out_n.mc_ic_ready = 1'b0;
          state_n           = ARB_REL;
        end else if (clear) begin
          out_n.mc_ic_ready = 1'b0;
          state_n           = ARB_REL;
        end
      end
`endif
      ARB_LSB: begin
        // A committed store must reach memory, so flush only aborts loads.
        if (bus.mc_lsb_done) begin
          out_n.lsb_done     = 1'b1;
          out_n.mc_lsb_ready = 1'b0;
          state_n            = ARB_REL;
        end else if (clear && !is_store) begin
          out_n.mc_lsb_ready = 1'b0;
          state_n            = ARB_REL;
        end
      end
      ARB_REL: state_n = ARB_IDLE;
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      starve_cnt <= '0;
      is_store   <= 1'b0;
      out_q      <= '0;
    end else if (rdy) begin
      state      <= state_n;
      starve_cnt <= starve_n;
      is_store   <= is_store_n;
      out_q      <= out_n;
    end
  end

  assign bus.ic_gnt       = out_q.ic_gnt;
  assign bus.ic_done      = out_q.ic_done;
  assign bus.lsb_gnt      = out_q.lsb_gnt;
  assign bus.lsb_done     = out_q.lsb_done;
  assign bus.mc_ic_ready  = out_q.mc_ic_ready;
  assign bus.mc_ic_addr   = out_q.mc_ic_addr;
  assign bus.mc_lsb_ready = out_q.mc_lsb_ready;
  assign bus.mc_lsb_addr  = out_q.mc_lsb.addr;
  assign bus.mc_lsb_op    = out_q.mc_lsb.op;
  assign bus.mc_lsb_imm   = out_q.mc_lsb.imm;
  assign bus.mc_lsb_val   = out_q.mc_lsb.val;

`ifdef MEM_ARB_PREFETCH_EN
  assign bus.pf_gnt  = out_q.pf_gnt;
  assign bus.pf_done = out_q.pf_done;
`else
  logic unused_pf;
  assign bus.pf_gnt  = 1'b0;
  assign bus.pf_done = 1'b0;
  assign unused_pf   = ^{bus.pf_req, bus.pf_addr, out_q.pf_gnt, out_q.pf_done, winner[REQ_PF]};
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level
// model of the arbiter's grant/complete/flush rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIM = 2;
`ifdef MEM_ARB_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif
  localparam int O_IDLE = 0, O_IC = 1, O_LSB = 2, O_PF = 3, O_REL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(LIM), .STARVE_W(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .rdy  (rdy),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the controller and what each output should be.
  int          m_own = O_IDLE;
  int          m_starve = 0;
  bit          m_store = 1'b0;
  logic        e_ic_gnt = 0, e_ic_done = 0, e_lsb_gnt = 0, e_lsb_done = 0, e_pf_gnt = 0, e_pf_done = 0;
  logic [31:0] e_ic_addr = 0, e_lsb_addr = 0, e_lsb_imm = 0, e_lsb_val = 0;
  logic [5:0]  e_lsb_op = 0;

  task automatic model_step();
    if (!rst) begin
      m_own = O_IDLE; m_starve = 0; m_store = 1'b0;
      {e_ic_gnt, e_ic_done, e_lsb_gnt, e_lsb_done, e_pf_gnt, e_pf_done} = '0;
      {e_ic_addr, e_lsb_addr, e_lsb_imm, e_lsb_val, e_lsb_op} = '0;
    end else if (rdy) begin
      {e_ic_gnt, e_ic_done, e_lsb_gnt, e_lsb_done, e_pf_gnt, e_pf_done} = '0;
      case (m_own)
        O_IDLE: if (!clear) begin
          if (bus.lsb_req && !(bus.ic_req && m_starve == LIM)) begin
            m_starve = bus.ic_req ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
            e_lsb_addr = bus.lsb_addr; e_lsb_op = bus.lsb_op;
            e_lsb_imm = bus.lsb_imm; e_lsb_val = bus.lsb_val;
            m_store = (bus.lsb_op[5:3] == 3'b111);
            e_lsb_gnt = 1'b1; m_own = O_LSB;
          end else if (bus.ic_req) begin
            m_starve = 0; e_ic_addr = bus.ic_addr; e_ic_gnt = 1'b1; m_own = O_IC;
          end else if (PF_EN && bus.pf_req) begin
            e_ic_addr = bus.pf_addr; e_pf_gnt = 1'b1; m_own = O_PF;
          end
        end
        O_IC, O_PF: begin
          if (bus.mc_ic_ok) begin
            if (m_own == O_IC) e_ic_done = 1'b1; else e_pf_done = 1'b1;
            m_own = O_REL;
          end else if (clear) m_own = O_REL;
        end
        O_LSB: begin
          if (bus.mc_lsb_done) begin e_lsb_done = 1'b1; m_own = O_REL; end
          else if (clear && !m_store) m_own = O_REL;
        end
        default: m_own = O_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ic_req = 0; bus.lsb_req = 0; bus.pf_req = 0;
    bus.mc_ic_ok = 0; bus.mc_lsb_done = 0;
    clear = 0; rdy = 1;
  endtask

  task automatic do_reset();
    rst = 0;
    idle_inputs();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; rdy = 1; clear = 0;
    bus.ic_req = 1; bus.lsb_req = 1; bus.pf_req = 1;
    bus.ic_addr = 32'h1111; bus.pf_addr = 32'h2222; bus.lsb_addr = 32'h3333;
    bus.lsb_op = OP_LW; bus.lsb_imm = 32'h4; bus.lsb_val = 32'h5;
    bus.mc_ic_ok = 0; bus.mc_lsb_done = 0;
    tick(); tick();
    n_chk++; if ({bus.ic_gnt, bus.ic_done, bus.lsb_gnt, bus.lsb_done, bus.pf_gnt, bus.pf_done, bus.mc_ic_ready, bus.mc_lsb_ready} !== 8'h00) begin n_fail++; $display("FAIL reset_ctl: got %b want 0", {bus.ic_gnt, bus.ic_done, bus.lsb_gnt, bus.lsb_done, bus.pf_gnt, bus.pf_done, bus.mc_ic_ready, bus.mc_lsb_ready}); end
    n_chk++; if ({bus.mc_ic_addr, bus.mc_lsb_addr, bus.mc_lsb_op, bus.mc_lsb_imm, bus.mc_lsb_val} !== '0) begin n_fail++; $display("FAIL reset_fields: got %h want 0", {bus.mc_ic_addr, bus.mc_lsb_addr, bus.mc_lsb_op, bus.mc_lsb_imm, bus.mc_lsb_val}); end
    rst = 1;
    tick();
    n_chk++; if ({bus.lsb_gnt, bus.mc_lsb_ready, bus.mc_ic_ready} !== 3'b110) begin n_fail++; $display("FAIL reset_first_grant: got %b want 110", {bus.lsb_gnt, bus.mc_lsb_ready, bus.mc_ic_ready}); end
    rst = 0;
    tick();
    n_chk++; if ({bus.lsb_gnt, bus.mc_lsb_ready, bus.mc_ic_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_midtxn: got %b want 000", {bus.lsb_gnt, bus.mc_lsb_ready, bus.mc_ic_ready}); end
    idle_inputs();
    rst = 1;
  endtask

  task automatic test_lsb_then_ic();
    do_reset();
    bus.ic_req = 1; bus.ic_addr = 32'h1000;
    bus.lsb_req = 1; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h20; bus.lsb_imm = 32'h4; bus.lsb_val = 32'h7;
    tick();
    n_chk++; if ({bus.lsb_gnt, bus.ic_gnt} !== 2'b10) begin n_fail++; $display("FAIL prio_gnt: got %b want 10", {bus.lsb_gnt, bus.ic_gnt}); end
    n_chk++; if ({bus.mc_lsb_addr, bus.mc_lsb_imm} !== {32'h20, 32'h4}) begin n_fail++; $display("FAIL prio_fields: got %h want 0000002000000004", {bus.mc_lsb_addr, bus.mc_lsb_imm}); end
    tick(); tick();
    bus.mc_lsb_done = 1;
    tick();
    bus.mc_lsb_done = 0; bus.lsb_req = 0;
    n_chk++; if ({bus.lsb_done, bus.mc_lsb_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_done: got %b want 10", {bus.lsb_done, bus.mc_lsb_ready}); end
    tick();
    n_chk++; if ({bus.ic_gnt, bus.lsb_done} !== 2'b00) begin n_fail++; $display("FAIL prio_release_gap: got %b want 00", {bus.ic_gnt, bus.lsb_done}); end
    tick();
    n_chk++; if ({bus.ic_gnt, bus.mc_ic_ready, bus.mc_ic_addr} !== {2'b11, 32'h1000}) begin n_fail++; $display("FAIL prio_ic_gnt: got %h want 3_00001000", {bus.ic_gnt, bus.mc_ic_ready, bus.mc_ic_addr}); end
    n_chk++; if (bus.mc_lsb_addr !== 32'h20) begin n_fail++; $display("FAIL prio_addr_hold: got %h want 20", bus.mc_lsb_addr); end
    bus.mc_ic_ok = 1;
    tick();
    bus.mc_ic_ok = 0; bus.ic_req = 0;
    n_chk++; if ({bus.ic_done, bus.mc_ic_ready} !== 2'b10) begin n_fail++; $display("FAIL prio_ic_done: got %b want 10", {bus.ic_done, bus.mc_ic_ready}); end
    tick();
  endtask

  task automatic test_starvation();
    int got[$];
    int exp_ord[6] = '{2, 2, 1, 2, 2, 1};
    do_reset();
    bus.ic_req = 1; bus.ic_addr = 32'h40;
    bus.lsb_req = 1; bus.lsb_op = OP_LB; bus.lsb_addr = 32'h80; bus.lsb_imm = 0;
    for (int k = 0; k < 100 && got.size() < 6; k++) begin
      tick();
      if (bus.lsb_gnt) got.push_back(2);
      if (bus.ic_gnt)  got.push_back(1);
      bus.mc_lsb_done = bus.mc_lsb_ready;
      bus.mc_ic_ok    = bus.mc_ic_ready;
    end
    n_chk++; if (got.size() != 6) begin n_fail++; $display("FAIL starve_count: got %0d grants want 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      n_chk++; if (i >= got.size() || got[i] != exp_ord[i]) begin n_fail++; $display("FAIL starve_order[%0d]: got %0d want %0d (2=LSB 1=IC)", i, (i < got.size()) ? got[i] : -1, exp_ord[i]); end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  task automatic test_clear_load();
    do_reset();
    bus.lsb_req = 1; bus.lsb_op = OP_LW; bus.lsb_addr = 32'h40; bus.lsb_imm = 0; bus.lsb_val = 32'h3;
    tick();
    n_chk++; if (bus.lsb_gnt !== 1'b1) begin n_fail++; $display("FAIL clr_ld_gnt: got %b want 1", bus.lsb_gnt); end
    tick(); tick();
    clear = 1;
    tick();
    clear = 0; bus.lsb_req = 0; bus.ic_req = 1; bus.ic_addr = 32'h2000;
    n_chk++; if ({bus.mc_lsb_ready, bus.lsb_done} !== 2'b00) begin n_fail++; $display("FAIL clr_ld_abort: got %b want 00", {bus.mc_lsb_ready, bus.lsb_done}); end
    tick();
    n_chk++; if ({bus.ic_gnt, bus.lsb_done} !== 2'b00) begin n_fail++; $display("FAIL clr_ld_release: got %b want 00", {bus.ic_gnt, bus.lsb_done}); end
    tick();
    n_chk++; if ({bus.ic_gnt, bus.mc_ic_addr} !== {1'b1, 32'h2000}) begin n_fail++; $display("FAIL clr_ld_idle: got %h want 1_00002000", {bus.ic_gnt, bus.mc_ic_addr}); end
    bus.mc_ic_ok = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_clear_store();
    do_reset();
    bus.lsb_req = 1; bus.lsb_op = OP_SW; bus.lsb_addr = 32'h30000; bus.lsb_imm = 0; bus.lsb_val = 32'hdeadbeef;
    tick();
    n_chk++; if ({bus.lsb_gnt, bus.mc_lsb_op, bus.mc_lsb_addr, bus.mc_lsb_val} !== {1'b1, OP_SW, 32'h30000, 32'hdeadbeef}) begin n_fail++; $display("FAIL clr_st_gnt: got %h", {bus.lsb_gnt, bus.mc_lsb_op, bus.mc_lsb_addr, bus.mc_lsb_val}); end
    tick(); tick();
    clear = 1;
    tick();
    clear = 0;
    n_chk++; if ({bus.mc_lsb_ready, bus.lsb_done} !== 2'b10) begin n_fail++; $display("FAIL clr_st_kept: got %b want 10", {bus.mc_lsb_ready, bus.lsb_done}); end
    tick();
    bus.mc_lsb_done = 1;
    tick();
    bus.mc_lsb_done = 0; bus.lsb_req = 0;
    n_chk++; if ({bus.lsb_done, bus.mc_lsb_ready} !== 2'b10) begin n_fail++; $display("FAIL clr_st_done: got %b want 10", {bus.lsb_done, bus.mc_lsb_ready}); end
    tick(); tick();
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    bus.ic_req = 1; bus.ic_addr = 32'h3000;
    tick();
    rdy = 0;
    for (int k = 0; k < 4; k++) begin
      bus.mc_ic_ok = (k == 1 || k == 2);
      tick();
      n_chk++; if ({bus.ic_gnt, bus.mc_ic_ready, bus.ic_done} !== 3'b110) begin n_fail++; $display("FAIL freeze[%0d]: got %b want 110", k, {bus.ic_gnt, bus.mc_ic_ready, bus.ic_done}); end
    end
    rdy = 1; bus.mc_ic_ok = 0;
    tick();
    n_chk++; if ({bus.ic_gnt, bus.mc_ic_ready, bus.ic_done} !== 3'b010) begin n_fail++; $display("FAIL thaw_busy: got %b want 010", {bus.ic_gnt, bus.mc_ic_ready, bus.ic_done}); end
    bus.mc_ic_ok = 1;
    tick();
    bus.mc_ic_ok = 0; bus.ic_req = 0;
    n_chk++; if ({bus.ic_gnt, bus.mc_ic_ready, bus.ic_done} !== 3'b001) begin n_fail++; $display("FAIL thaw_done: got %b want 001", {bus.ic_gnt, bus.mc_ic_ready, bus.ic_done}); end
    tick();
  endtask

  task automatic test_pf();
    do_reset();
    bus.pf_req = 1; bus.pf_addr = 32'h5000;
    tick();
    n_chk++; if ({bus.pf_gnt, bus.mc_ic_ready, bus.mc_ic_addr} !== {PF_EN, PF_EN, PF_EN ? 32'h5000 : 32'h0}) begin n_fail++; $display("FAIL pf_alone: got %h want pf_en=%0d", {bus.pf_gnt, bus.mc_ic_ready, bus.mc_ic_addr}, PF_EN); end
    bus.mc_ic_ok = 1;
    tick();
    bus.mc_ic_ok = 0;
    n_chk++; if (bus.pf_done !== PF_EN) begin n_fail++; $display("FAIL pf_done: got %b want %b", bus.pf_done, PF_EN); end
    do_reset();
    bus.pf_req = 1; bus.pf_addr = 32'h7000; bus.ic_req = 1; bus.ic_addr = 32'h6000;
    tick();
    n_chk++; if ({bus.ic_gnt, bus.pf_gnt, bus.mc_ic_addr} !== {2'b10, 32'h6000}) begin n_fail++; $display("FAIL pf_vs_ic: got %h want 2_00006000", {bus.ic_gnt, bus.pf_gnt, bus.mc_ic_addr}); end
    bus.mc_ic_ok = 1;
    tick();
    bus.mc_ic_ok = 0; bus.ic_req = 0;
    tick(); tick();
    n_chk++; if (bus.pf_gnt !== PF_EN) begin n_fail++; $display("FAIL pf_after_ic: got %b want %b", bus.pf_gnt, PF_EN); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    logic [7:0] got_ctl, exp_ctl;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 79) != 0);
      rdy   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 11) == 0);
      bus.ic_req  = ($urandom_range(0, 3) != 0);
      bus.lsb_req = ($urandom_range(0, 3) != 0);
      bus.pf_req  = ($urandom_range(0, 2) != 0);
      bus.ic_addr = $urandom; bus.pf_addr = $urandom;
      bus.lsb_addr = $urandom; bus.lsb_imm = $urandom; bus.lsb_val = $urandom;
      bus.lsb_op = ops[$urandom_range(0, 7)];
      bus.mc_ic_ok    = ($urandom_range(0, 3) == 0);
      bus.mc_lsb_done = ($urandom_range(0, 3) == 0);
      tick();
      got_ctl = {bus.ic_gnt, bus.ic_done, bus.lsb_gnt, bus.lsb_done, bus.pf_gnt, bus.pf_done, bus.mc_ic_ready, bus.mc_lsb_ready};
      exp_ctl = {e_ic_gnt, e_ic_done, e_lsb_gnt, e_lsb_done, e_pf_gnt, e_pf_done, (m_own == O_IC || m_own == O_PF), (m_own == O_LSB)};
      n_chk++; if (got_ctl !== exp_ctl) begin n_fail++; $display("FAIL rand_ctl @%0d: got %b want %b", k, got_ctl, exp_ctl); end
      n_chk++; if ({bus.mc_ic_addr, bus.mc_lsb_addr, bus.mc_lsb_op, bus.mc_lsb_imm, bus.mc_lsb_val} !== {e_ic_addr, e_lsb_addr, e_lsb_op, e_lsb_imm, e_lsb_val}) begin n_fail++; $display("FAIL rand_fields @%0d: got %h want %h", k, {bus.mc_ic_addr, bus.mc_lsb_addr, bus.mc_lsb_op, bus.mc_lsb_imm, bus.mc_lsb_val}, {e_ic_addr, e_lsb_addr, e_lsb_op, e_lsb_imm, e_lsb_val}); end
      n_chk++; if (bus.mc_ic_ready === 1'b1 && bus.mc_lsb_ready === 1'b1) begin n_fail++; $display("FAIL rand_ready_excl @%0d: got both readies high want at most one", k); end
    end
    rst = 1;
    idle_inputs();
    tick();
  endtask

  initial begin
    bus.ic_addr = 0; bus.pf_addr = 0; bus.lsb_addr = 0; bus.lsb_op = 0; bus.lsb_imm = 0; bus.lsb_val = 0;
    idle_inputs();
    test_reset();
    test_lsb_then_ic();
    test_starvation();
    test_clear_load();
    test_clear_store();
    test_rdy_freeze();
    test_pf();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
